// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - system-ID slave read-back checker (Avalon-MM master)
// Optional retry on mismatch: define SYSID_CHECK_RETRY_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1485992024,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic [3:0]  retry_count
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_e;

  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  stall_q, stall_d;
  logic [31:0] id_word_q, id_word_d;
  logic [31:0] ts_word_q, ts_word_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        armed_q;
  logic        go;
  logic        mismatch;
  logic        retry_go;

`ifdef SYSID_CHECK_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
  logic [3:0] retry_q, retry_d;
  assign retry_count = retry_q;
`else
  logic [3:0] unused_retry_cfg;
  assign unused_retry_cfg = 4'(MAX_RETRIES);
  assign retry_count      = 4'd0;
`endif

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    id_word_d = id_word_q;
    ts_word_d = ts_word_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    retry_go  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
    retry_d   = retry_q;
`endif
    // armed_q is low only in the first cycle after reset release
    go       = start || (AUTO_START && !armed_q);
    mismatch = (id_word_q != EXPECTED_ID) || (ts_word_q != EXPECTED_TS);

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RD_ID;
          stall_d = 8'd0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
          retry_d = 4'd0;
`endif
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          stall_d = 8'd0;
          if (state_q == RD_ID) begin
            id_word_d = avm_readdata;
            state_d   = RD_TS;
          end else begin
            ts_word_d = avm_readdata;
            state_d   = CHECK;
          end
        end else if (stall_q == STALL_LAST) begin
          stall_d = 8'd0;
          tmo_d   = 1'b1;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      CHECK: begin
`ifdef SYSID_CHECK_RETRY_EN
        retry_go = mismatch && (retry_q < RETRY_LIMIT);
`endif
        if (retry_go) begin
`ifdef SYSID_CHECK_RETRY_EN
          retry_d = retry_q + 4'd1;
`endif
          state_d = RD_ID;
        end else begin
          id_ok_d = (id_word_q == EXPECTED_ID);
          ts_ok_d = (ts_word_q == EXPECTED_TS);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      stall_q   <= 8'd0;
      id_word_q <= 32'd0;
      ts_word_q <= 32'd0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      tmo_q     <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
      retry_q   <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      armed_q   <= 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address = (state_q == RD_TS);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_q;
  assign id_word     = id_word_q;
  assign ts_word     = ts_word_q;

endmodule
